// File: rtl/multi_bit_adder.sv
// ---------------------------------------------------------------------------
// multi_bit_adder
//
// Purpose:
//   WIDTH-bit unsigned ripple-carry adder with carry-in and carry-out. The
//   combinational sum is available immediately. A one-cycle registered stage
//   also captures the result together with signed-overflow and zero flags,
//   for synchronous datapath consumers such as ALUs and accumulators.
//
// Parameters:
//   WIDTH        operand and sum width in bits (>= 1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   Data_1       operand A (unsigned)
//   Data_2       operand B (unsigned)
//   Carry_in     carry into bit 0
//   in_valid     capture the current operands into the result register
//   Sum          combinational sum bits
//   Carry_out    combinational carry out of the MSB
//   Sum_q        registered sum
//   Carry_out_q  registered carry out
//   Overflow_q   registered two's-complement overflow
//   Zero_q       registered flag, set when {Carry_out,Sum} == 0
//   out_valid    the registered results are valid this cycle
// ---------------------------------------------------------------------------
module multi_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Data_1,
  input  logic [WIDTH-1:0] Data_2,
  input  logic             Carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_out,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Carry_out_q,
  output logic             Overflow_q,
  output logic             Zero_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   carry_chain;
  logic             carry;
  logic             overflow;
  logic             zero;

  // Ripple chain of full-adder cells. The running carry is held in a single
  // variable so the chain reads as a straight sequence and does not become a
  // self-referencing vector. Every carry is kept in carry_chain because the
  // overflow flag needs the carry into the MSB as well as the carry out.
  always_comb begin
    sum_bits    = '0;
    carry_chain = '0;
    carry       = Carry_in;
    carry_chain[0] = Carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum_bits[i]        = Data_1[i] ^ Data_2[i] ^ carry;
      carry              = (Data_1[i] & Data_2[i]) | (carry & (Data_1[i] ^ Data_2[i]));
      carry_chain[i+1]   = carry;
    end
  end

  assign Sum       = sum_bits;
  assign Carry_out = carry_chain[WIDTH];

  // Signed overflow occurs when the carry into the MSB differs from the carry
  // out of it. When WIDTH is 1, the carry into the MSB is Carry_in itself.
  // The zero flag covers the full WIDTH+1-bit result, so a wrap to zero that
  // produces a carry does not count as zero.
  assign overflow = carry_chain[WIDTH] ^ carry_chain[WIDTH-1];
  assign zero     = ({carry_chain[WIDTH], sum_bits} == '0);

  // Result register. Reset takes priority over a capture. When in_valid is
  // low, the data registers keep their last result and only out_valid drops,
  // so a downstream consumer can still read the previous sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum_q       <= '0;
      Carry_out_q <= 1'b0;
      Overflow_q  <= 1'b0;
      Zero_q      <= 1'b0;
      out_valid   <= 1'b0;
    end else if (in_valid) begin
      Sum_q       <= sum_bits;
      Carry_out_q <= carry_chain[WIDTH];
      Overflow_q  <= overflow;
      Zero_q      <= zero;
      out_valid   <= 1'b1;
    end else begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_bit_adder.sv
// ---------------------------------------------------------------------------
// tb_multi_bit_adder
//
// Purpose:
//   Self-checking bench for multi_bit_adder with WIDTH = 4. When an operand
//   set is captured, its expected registered result is queued. A monitor pops
//   the queue one cycle later and compares it with the registered outputs.
//   The combinational outputs are checked 10 ns after each input change.
// ---------------------------------------------------------------------------
module tb_multi_bit_adder;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } result_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] Data_1;
  logic [WIDTH-1:0] Data_2;
  logic             Carry_in;
  logic             in_valid;
  logic [WIDTH-1:0] Sum;
  logic             Carry_out;
  logic [WIDTH-1:0] Sum_q;
  logic             Carry_out_q;
  logic             Overflow_q;
  logic             Zero_q;
  logic             out_valid;

  result_t scoreboard[$];
  int      vectors;
  int      miscompares;

  multi_bit_adder #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .Data_1      (Data_1),
    .Data_2      (Data_2),
    .Carry_in    (Carry_in),
    .in_valid    (in_valid),
    .Sum         (Sum),
    .Carry_out   (Carry_out),
    .Sum_q       (Sum_q),
    .Carry_out_q (Carry_out_q),
    .Overflow_q  (Overflow_q),
    .Zero_q      (Zero_q),
    .out_valid   (out_valid)
  );

  // 20 ns clock. Inputs change 1 ns after a rising edge, so the check made
  // 10 ns later still falls well before the next edge.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // All comparisons go through this task. It counts each comparison and
  // reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model. The arithmetic is done on plain integers, and the signed
  // overflow is found by checking whether the true signed sum fits in range.
  function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic cin);
    result_t r;
    int total;
    int sa;
    int sb;
    int ssum;
    total  = int'(a) + int'(b) + int'(cin);
    sa     = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
    sb     = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
    ssum   = sa + sb + int'(cin);
    r.sum  = total[WIDTH-1:0];
    r.cout = total[WIDTH];
    r.ovf  = (ssum > (1 << (WIDTH-1)) - 1) || (ssum < -(1 << (WIDTH-1)));
    r.zero = (total == 0);
    return r;
  endfunction

  // Applies one operand set just after a rising edge. If the set will be
  // captured, its expected result is queued. The task then checks the
  // combinational outputs 10 ns later.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic valid, input logic reset_v);
    result_t exp_r;
    @(posedge clk);
    #1;
    Data_1   = a;
    Data_2   = b;
    Carry_in = cin;
    in_valid = valid;
    rst      = reset_v;
    exp_r    = model(a, b, cin);
    if (valid && !reset_v) scoreboard.push_back(exp_r);
    #10;
    checkOutput("comb_sum", 32'(Sum), 32'(exp_r.sum));
    checkOutput("comb_cout", 32'(Carry_out), 32'(exp_r.cout));
  endtask

  // Registered-path monitor. It samples the control inputs on each rising
  // edge and predicts what the edge should have done. 1 ns later it compares
  // that prediction with the outputs. A held copy of the last capture checks
  // that the data registers keep their value while in_valid is low.
  initial begin : monitor
    result_t held;
    result_t exp_r;
    logic    s_rst;
    logic    s_valid;
    held = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    forever begin
      @(posedge clk);
      s_rst   = rst;
      s_valid = in_valid;
      #1;
      if (s_rst) begin
        held = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
      end else if (s_valid) begin
        if (scoreboard.size() == 0) begin
          checkOutput("sb_underflow", 32'd0, 32'd1);
        end else begin
          exp_r = scoreboard.pop_front();
          held  = exp_r;
        end
        checkOutput("out_valid", 32'(out_valid), 32'd1);
      end else begin
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
      end
      checkOutput("Sum_q", 32'(Sum_q), 32'(held.sum));
      checkOutput("Carry_out_q", 32'(Carry_out_q), 32'(held.cout));
      checkOutput("Overflow_q", 32'(Overflow_q), 32'(held.ovf));
      checkOutput("Zero_q", 32'(Zero_q), 32'(held.zero));
    end
  end

  // Test sequence: reset, the directed corner cases, a reset in the middle
  // of a stream of back-to-back captures, and then an exhaustive sweep in
  // which in_valid is randomised so that the hold path is also exercised.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    Data_1      = '0;
    Data_2      = '0;
    Carry_in    = 1'b0;

    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    applyStimulus(4'd0,  4'd0,  1'b0, 1'b1, 1'b0);
    applyStimulus(4'd10, 4'd11, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'd12, 4'd4,  1'b0, 1'b1, 1'b0);
    applyStimulus(4'd15, 4'd9,  1'b1, 1'b1, 1'b0);
    applyStimulus(4'd2,  4'd15, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd7,  4'd7,  1'b1, 1'b1, 1'b0);
    applyStimulus(4'd5,  4'd3,  1'b0, 1'b1, 1'b0);
    applyStimulus(4'd15, 4'd0,  1'b1, 1'b1, 1'b0);
    applyStimulus(4'd15, 4'd15, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd3,  4'd4,  1'b0, 1'b0, 1'b0);
    applyStimulus(4'd9,  4'd1,  1'b1, 1'b0, 1'b0);

    applyStimulus(4'd8, 4'd8, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'd9, 4'd9, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'd6, 4'd7, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'd1, 4'd2, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'd4, 4'd4, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      applyStimulus(v[7:4], v[3:0], v[8], 1'($urandom_range(0, 1)), 1'b0);
    end

    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sb_empty", 32'(scoreboard.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
